i2c_codec_responder: RTL and testbench
======================================

Name: i2c_codec_responder

Overview:
- I2C write-only target (responder) for the 3-byte codec configuration transactions: device address, then two register bytes.
- Decodes START/STOP, matches the 7-bit device address, ACKs by pulling SDA low, and assembles each 16-bit word into a 7-bit register address and 9-bit register data.
- Used as the on-chip codec register model in simulation and loopback, and as the protocol checker for the initializer side.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address (address byte 0x34 with write bit).
- SYNC_STAGES, 2, synchronizer flops on i_sclk/i_sdat (minimum 2).

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCL rate.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_sclk  in  1  I2C SCL as seen on the bus (asynchronous).
- i_sdat  in  1  I2C SDA as seen on the bus (asynchronous).
- o_sdat_low  out  1  1 = pull SDA low (ACK); 0 = release; an external open-drain driver applies it.
- o_reg_valid  out  1  one-cycle strobe; a complete register word was received.
- o_reg_addr  out  7  byte1[7:1]; held until the next strobe.
- o_reg_data  out  9  {byte1[0], byte2[7:0]}; held until the next strobe.
- o_busy  out  1  high from an accepted START until STOP or abort.
- o_err  out  1  sticky; set on a protocol abort; cleared only by reset.

Behaviour:
- Reset (async assert, sync release) values: all outputs 0, state IDLE, shift register 0, bit counter 0.
- Input path: SYNC_STAGES flops, then one previous-value register per line.
  - Fixed detection latency from a pin change to the internal event is SYNC_STAGES+1 cycles.
- Events on synchronized signals:
  - SCL_RISE, SCL_FALL.
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
- Data sampling:
  - Data bits are sampled on SCL_RISE, MSB first, into an 8-bit shift register.
  - An SDA change while SCL is high is never treated as data.
- States:
  - IDLE: wait for START.
  - ADDR: 8 bits.
  - ACK_A.
  - BYTE1: 8 bits.
  - ACK_1.
  - BYTE2: 8 bits.
  - ACK_2.
  - IGNORE: wait for STOP/START.
- START in any state (including repeated start): go to ADDR, clear bit counter, drop o_sdat_low, set o_busy.
  - A partial word is discarded.
- STOP in any state: go to IDLE, drop o_sdat_low and o_busy, no strobe.
  - A STOP before ACK_2 completes is a legal abort, and o_err is not set.
- ADDR, after the 8th SCL_RISE:
  - If byte[7:1]==DEV_ADDR and byte[0]==0, go to ACK_A.
  - Otherwise (address mismatch or read bit) go to IGNORE and never drive SDA.
- ACK phases (ACK_A/ACK_1/ACK_2):
  - On the first SCL_FALL after the 8th bit, assert o_sdat_low.
  - Keep it through the 9th SCL high.
  - Release on the following SCL_FALL, then move to the next byte state.
- Word strobe:
  - o_reg_valid pulses one cycle on the same cycle o_sdat_low asserts in ACK_2.
  - o_reg_addr/o_reg_data update on that cycle.
- After ACK_2, go to IGNORE: further bytes get no ACK (NACK).
  - Only STOP or START exits IGNORE.
- o_err is set when SDA is sampled low while the responder should be released in IGNORE after ACK_2 completes.
  - This is the controller driving extra data; the bytes are still NACKed.
- Bit counter: 4 bits, 0..8, cleared on START and on each byte-state entry. No wrap is permitted.
- Reset mid-transaction: return to IDLE immediately.
  - SDA is released asynchronously, since o_sdat_low is reset directly.
- Simultaneous SCL and SDA change in the same synchronized cycle: treat as an SCL edge only; no START/STOP.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE);
  - the default DEV_ADDR;
  - the RW_WRITE constant;
  - the codec register address constants shared with the initializer (e.g. REG_RESET=7'h0F, REG_ACTIVE=7'h09).
- Sub-module i2c_line_sync holds the synchronizers, the previous-value registers, and the SCL_RISE/SCL_FALL/START/STOP pulse generation.

Test Plan:
- Write 0x34,0x1E,0x00 then STOP:
  - ACK on all three bytes;
  - one o_reg_valid with addr=7'h0F, data=9'h000;
  - o_busy low after STOP.
- Write 0x34,0x08,0x15:
  - addr=7'h04, data=9'h015;
  - o_sdat_low asserts exactly in the three 9th-clock windows.
- Address 0x36, or 0x35 (read bit set): SDA is never driven, no strobe, o_err stays 0.
- STOP after 0x34,0x10: no strobe; the next full write 0x34,0x12,0x01 gives addr=7'h09, data=9'h001.
- Repeated START after byte1, then 0x34,0x0C,0x00: a single strobe with addr=7'h06, data=9'h000.
- Fourth byte 0x55 after a full word: that byte is NACKed, o_err=1; assert i_rst_n=0 mid-byte and all outputs read 0 immediately.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the codec I2C responder and its initializer: FSM states,
// bus constants and the codec register map entries both sides refer to.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    BYTE1,
    ACK_1,
    BYTE2,
    ACK_2,
    IGNORE
  } state_t;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;
  localparam logic       RW_WRITE         = 1'b0;
  localparam logic [3:0] LAST_BIT_IDX     = 4'd7;

  // Codec registers written by the initializer
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock domain and produces registered
// one-cycle bus event pulses (SCL edges, START, STOP).
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_sdat,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_q
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Lines reset to the idle-bus level so release never looks like an edge.
  // START/STOP need SCL stable high across both samples, so an SDA change
  // landing together with an SCL edge counts only as the SCL edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_q     <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], i_sclk};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], i_sdat};
      scl_prev  <= scl_s;
      sda_prev  <= sda_s;
      scl_rise  <= scl_s & ~scl_prev;
      scl_fall  <= ~scl_s & scl_prev;
      start_det <= scl_s & scl_prev & sda_prev & ~sda_s;
      stop_det  <= scl_s & scl_prev & ~sda_prev & sda_s;
      sda_q     <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target for 3-byte codec configuration writes: address byte,
// then a 16-bit word split into a 7-bit register address and 9-bit data.
module i2c_codec_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sdat_low,
  output logic       o_reg_valid,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_busy,
  output logic       o_err
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_q;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_sclk    (i_sclk),
    .i_sdat    (i_sdat),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_q     (sda_q)
  );

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] byte1, byte1_n;
  logic       post_word, post_word_n;
  logic       pend_low, pend_low_n;
  logic       sdat_low_n, reg_valid_n, busy_n, err_n;
  logic [6:0] reg_addr_n;
  logic [8:0] reg_data_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      byte1       <= '0;
      post_word   <= 1'b0;
      pend_low    <= 1'b0;
      o_sdat_low  <= 1'b0;
      o_reg_valid <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_data  <= '0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      byte1       <= byte1_n;
      post_word   <= post_word_n;
      pend_low    <= pend_low_n;
      o_sdat_low  <= sdat_low_n;
      o_reg_valid <= reg_valid_n;
      o_reg_addr  <= reg_addr_n;
      o_reg_data  <= reg_data_n;
      o_busy      <= busy_n;
      o_err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    byte1_n     = byte1;
    post_word_n = post_word;
    pend_low_n  = pend_low;
    sdat_low_n  = o_sdat_low;
    reg_valid_n = 1'b0;
    reg_addr_n  = o_reg_addr;
    reg_data_n  = o_reg_data;
    busy_n      = o_busy;
    err_n       = o_err;

    if (start_det) begin
      state_n     = ADDR;
      bit_cnt_n   = '0;
      sdat_low_n  = 1'b0;
      busy_n      = 1'b1;
      post_word_n = 1'b0;
      pend_low_n  = 1'b0;
    end else if (stop_det) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      sdat_low_n  = 1'b0;
      busy_n      = 1'b0;
      post_word_n = 1'b0;
      pend_low_n  = 1'b0;
    end else begin
      unique case (state)
        ADDR, BYTE1, BYTE2: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_q};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT_IDX) begin
              if (state == ADDR) begin
                if (shreg_n[7:1] == DEV_ADDR && shreg_n[0] == RW_WRITE) state_n = ACK_A;
                else                                                     state_n = IGNORE;
              end else if (state == BYTE1) begin
                byte1_n = shreg_n;
                state_n = ACK_1;
              end else begin
                state_n = ACK_2;
              end
            end
          end
        end
        // The first fall drives the ACK, the second one (after the 9th clock) ends it
        ACK_A, ACK_1, ACK_2: begin
          if (scl_fall) begin
            if (!o_sdat_low) begin
              sdat_low_n = 1'b1;
              if (state == ACK_2) begin
                reg_valid_n = 1'b1;
                reg_addr_n  = byte1[7:1];
                reg_data_n  = {byte1[0], shreg};
              end
            end else begin
              sdat_low_n = 1'b0;
              bit_cnt_n  = '0;
              if (state == ACK_A) begin
                state_n = BYTE1;
              end else if (state == ACK_1) begin
                state_n = BYTE2;
              end else begin
                state_n     = IGNORE;
                post_word_n = 1'b1;
              end
            end
          end
        end
        // A low sample only counts as extra data once SCL falls again; a STOP
        // also samples SDA low on its final rise but never reaches that fall.
        IGNORE: begin
          if (post_word) begin
            if (scl_rise) pend_low_n = ~sda_q;
            if (scl_fall && pend_low) begin
              err_n      = 1'b1;
              pend_low_n = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: table vectors, randomized transactions against a
// byte-level reference model, and hand sequences for aborts, restarts and reset.
module tb_i2c_codec_responder;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       ctrl_sda = 1'b1;
  logic       sdat_bus;
  logic       o_sdat_low, o_reg_valid, o_busy, o_err;
  logic [6:0] o_reg_addr;
  logic [8:0] o_reg_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  int strobe_cnt = 0;

  typedef struct {
    logic [3:0][7:0] b;
    int              n;
    logic [3:0]      ack;
    int              nstrobe;
    logic [6:0]      addr;
    logic [8:0]      data;
    bit              err;
  } vec_t;

  assign sdat_bus = ctrl_sda & ~o_sdat_low;

  always #5 clk = ~clk;

  i2c_codec_responder #(
    .DEV_ADDR    (7'h1A),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sclk      (scl),
    .i_sdat      (sdat_bus),
    .o_sdat_low  (o_sdat_low),
    .o_reg_valid (o_reg_valid),
    .o_reg_addr  (o_reg_addr),
    .o_reg_data  (o_reg_data),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always @(negedge clk) if (o_reg_valid === 1'b1) strobe_cnt++;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    scl = 1'b1;
    ctrl_sda = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic i2c_start();
    ctrl_sda = 1'b1; wait_clk(Q);
    scl = 1'b1;      wait_clk(Q);
    ctrl_sda = 1'b0; wait_clk(Q);
    scl = 1'b0;      wait_clk(Q);
  endtask

  task automatic i2c_stop();
    ctrl_sda = 1'b0; wait_clk(Q);
    scl = 1'b1;      wait_clk(Q);
    ctrl_sda = 1'b1; wait_clk(Q);
  endtask

  // Eight data bits; drv reports whether the responder pulled SDA during any of them
  task automatic send_bits(input logic [7:0] b, output bit drv);
    drv = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      ctrl_sda = b[i]; wait_clk(Q);
      scl = 1'b1;      wait_clk(Q / 2);
      @(negedge clk);
      if (o_sdat_low) drv = 1'b1;
      wait_clk(Q / 2);
      scl = 1'b0;      wait_clk(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack, output bit drv);
    send_bits(b, drv);
    ctrl_sda = 1'b1; wait_clk(Q);
    scl = 1'b1;      wait_clk(Q / 2);
    @(negedge clk);
    ack = o_sdat_low;
    wait_clk(Q / 2);
    scl = 1'b0;      wait_clk(Q);
  endtask

  function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int n, input logic [3:0] ack,
                              input int ns, input logic [6:0] addr, input logic [8:0] data,
                              input bit err);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.n = n; v.ack = ack; v.nstrobe = ns; v.addr = addr; v.data = data; v.err = err;
    return v;
  endfunction

  // Byte-level model: a write to 0x34 acks three bytes and yields one word once
  // all three arrived; any extra byte containing a 0 bit is flagged.
  function automatic vec_t model(input logic [3:0][7:0] b, input int n);
    vec_t v;
    bit   match;
    v.b = b; v.n = n; v.ack = '0; v.err = 1'b0;
    match = (n >= 1) && (int'(b[0]) == 2 * 'h1A);
    for (int i = 0; i < n; i++) v.ack[i] = match && (i < 3);
    v.nstrobe = (match && n >= 3) ? 1 : 0;
    v.addr = 7'(int'(b[1]) / 2);
    v.data = 9'((int'(b[1]) % 2) * 256 + int'(b[2]));
    for (int i = 3; i < n; i++) if (b[i] != 8'hFF && match) v.err = 1'b1;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    bit ack, drv;
    do_reset();
    base = strobe_cnt;
    i2c_start();
    check({tag, " busy_after_start"}, int'(o_busy), 1);
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.b[i], ack, drv);
      check({tag, " ack"}, int'(ack), int'(v.ack[i]));
      check({tag, " no_drive_in_data"}, int'(drv), 0);
    end
    i2c_stop();
    wait_clk(Q);
    @(negedge clk);
    check({tag, " strobes"}, strobe_cnt - base, v.nstrobe);
    if (v.nstrobe > 0) begin
      check({tag, " reg_addr"}, int'(o_reg_addr), int'(v.addr));
      check({tag, " reg_data"}, int'(o_reg_data), int'(v.data));
    end
    check({tag, " err"}, int'(o_err), int'(v.err));
    check({tag, " busy_after_stop"}, int'(o_busy), 0);
    check({tag, " sdat_released"}, int'(o_sdat_low), 0);
  endtask

  vec_t            vecs[7];
  vec_t            rv;
  logic [3:0][7:0] rb;
  bit              ack, drv;
  int              base;

  initial begin
    vecs[0] = mk(8'h34, 8'h1E, 8'h00, 8'h00, 3, 4'b0111, 1, 7'h0F, 9'h000, 1'b0);
    vecs[1] = mk(8'h34, 8'h08, 8'h15, 8'h00, 3, 4'b0111, 1, 7'h04, 9'h015, 1'b0);
    vecs[2] = mk(8'h36, 8'h1E, 8'h00, 8'h00, 3, 4'b0000, 0, 7'h00, 9'h000, 1'b0);
    vecs[3] = mk(8'h35, 8'h1E, 8'h00, 8'h00, 3, 4'b0000, 0, 7'h00, 9'h000, 1'b0);
    vecs[4] = mk(8'h34, 8'h1E, 8'h00, 8'h55, 4, 4'b0111, 1, 7'h0F, 9'h000, 1'b1);
    vecs[5] = mk(8'h34, 8'h13, 8'hFF, 8'hFF, 4, 4'b0111, 1, 7'h09, 9'h1FF, 1'b0);
    vecs[6] = mk(8'h34, 8'h10, 8'h00, 8'h00, 2, 4'b0011, 0, 7'h00, 9'h000, 1'b0);

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst sdat_low", int'(o_sdat_low), 0);
    check("rst reg_valid", int'(o_reg_valid), 0);
    check("rst reg_addr", int'(o_reg_addr), 0);
    check("rst reg_data", int'(o_reg_data), 0);
    check("rst busy", int'(o_busy), 0);
    check("rst err", int'(o_err), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    rb[0] = 8'h34;
        2:       rb[0] = ($urandom_range(0, 1) != 0) ? 8'h35 : 8'h36;
        default: rb[0] = 8'($urandom);
      endcase
      for (int k = 1; k < 4; k++) rb[k] = 8'($urandom);
      if ($urandom_range(0, 1) != 0) rb[3] = 8'hFF;
      rv = model(rb, int'($urandom_range(1, 4)));
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Simultaneous SCL rise and SDA fall is an SCL edge, not a START
    do_reset();
    scl = 1'b0; wait_clk(Q);
    scl = 1'b1; ctrl_sda = 1'b0; wait_clk(Q);
    @(negedge clk);
    check("simul_edge no_start", int'(o_busy), 0);
    scl = 1'b0; wait_clk(Q);
    ctrl_sda = 1'b1; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);

    // STOP after a partial word, then a full write without reset
    do_reset();
    base = strobe_cnt;
    i2c_start();
    send_byte(8'h34, ack, drv);
    send_byte(8'h10, ack, drv);
    i2c_stop();
    wait_clk(Q);
    check("abort strobes", strobe_cnt - base, 0);
    check("abort err", int'(o_err), 0);
    i2c_start();
    send_byte(8'h34, ack, drv);
    send_byte(8'h12, ack, drv);
    send_byte(8'h01, ack, drv);
    check("after_abort ack2", int'(ack), 1);
    i2c_stop();
    wait_clk(Q);
    @(negedge clk);
    check("after_abort strobes", strobe_cnt - base, 1);
    check("after_abort addr", int'(o_reg_addr), 'h09);
    check("after_abort data", int'(o_reg_data), 'h001);

    // Repeated START after byte1 discards the partial word
    do_reset();
    base = strobe_cnt;
    i2c_start();
    send_byte(8'h34, ack, drv);
    send_byte(8'h1E, ack, drv);
    i2c_start();
    check("rstart busy", int'(o_busy), 1);
    send_byte(8'h34, ack, drv);
    check("rstart addr_ack", int'(ack), 1);
    send_byte(8'h0C, ack, drv);
    send_byte(8'h00, ack, drv);
    i2c_stop();
    wait_clk(Q);
    @(negedge clk);
    check("rstart strobes", strobe_cnt - base, 1);
    check("rstart addr", int'(o_reg_addr), 'h06);
    check("rstart data", int'(o_reg_data), 'h000);

    // Extra byte sets err; then an asynchronous reset during an ACK clears everything
    do_reset();
    i2c_start();
    send_byte(8'h34, ack, drv);
    send_byte(8'h1E, ack, drv);
    send_byte(8'h00, ack, drv);
    send_byte(8'h55, ack, drv);
    check("extra nack", int'(ack), 0);
    check("extra err", int'(o_err), 1);
    i2c_start();
    send_byte(8'h34, ack, drv);
    send_bits(8'h1E, drv);
    ctrl_sda = 1'b1; wait_clk(Q);
    scl = 1'b1;      wait_clk(Q / 2);
    @(negedge clk);
    check("pre_rst sdat_low", int'(o_sdat_low), 1);
    check("pre_rst busy", int'(o_busy), 1);
    check("pre_rst err", int'(o_err), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst sdat_low", int'(o_sdat_low), 0);
    check("async_rst busy", int'(o_busy), 0);
    check("async_rst err", int'(o_err), 0);
    check("async_rst reg_addr", int'(o_reg_addr), 0);
    check("async_rst reg_data", int'(o_reg_data), 0);
    check("async_rst reg_valid", int'(o_reg_valid), 0);
    wait_clk(2);
    scl = 1'b1; ctrl_sda = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
